// File: rtl/uart_mmio.sv
// Memory-mapped console responder: DATA/STATUS registers in front of a TX FIFO that is
// drained to the harness UART character interface with a fixed inter-character gap.
//
// state | meaning
// IDLE  | waiting for the TX FIFO to hold at least one character
// SEND  | FIFO head presented on uart_out_*, popped at the end of this cycle
// GAP   | idle spacing after a character, counting down to zero
module uart_mmio #(
    parameter int FIFO_DEPTH = 8,
    parameter int TX_GAP     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wmask_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        uart_out_valid_o,
    output logic [7:0]  uart_out_ch_o,
    output logic        uart_in_valid_o,
    input  logic [7:0]  uart_in_ch_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = (TX_GAP > 0) ? GW'(TX_GAP - 1) : '0;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            resp_valid_q;
    logic [63:0]     resp_rdata_q, resp_rdata_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_ch_q, out_ch_d;

    logic            is_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            push;
    logic            pop;
    logic [31:0]     count_ext;
    logic [7:0]      status;
    logic            unused_ok;

    assign is_data    = ~req_addr_i[3];
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign count_ext  = 32'(count_q);

    // Only a store that would overflow the FIFO is back-pressured.
    assign req_ready_o     = ~(req_valid_i & req_wen_i & is_data & fifo_full);
    assign accept          = req_valid_i & req_ready_o;
    assign push            = accept & req_wen_i & is_data & req_wmask_i[0];
    assign uart_in_valid_o = rst_ni & accept & ~req_wen_i & is_data;
    assign pop             = (state_q == ST_SEND);

    assign unused_ok = ^{req_addr_i[63:4], req_addr_i[2:0], req_wdata_i[63:8], req_wmask_i[7:1]};

    always_comb begin
        status      = 8'd0;
        status[0]   = fifo_full;
        status[1]   = fifo_empty;
        status[7:4] = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    end

    always_comb begin
        resp_rdata_d = 64'd0;
        if (accept && !req_wen_i) begin
            resp_rdata_d = is_data ? {56'd0, uart_in_ch_i} : {56'd0, status};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            resp_valid_q <= accept;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_wdata_i[7:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Outputs are computed from the next state so they are registered yet aligned with SEND.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        out_valid_d = 1'b0;
        out_ch_d    = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (TX_GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_INIT;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_SEND) begin
            out_valid_d = 1'b1;
            out_ch_d    = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign uart_out_valid_o = out_valid_q;
    assign uart_out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized self-checking bench for uart_mmio; the reference model predicts FIFO occupancy
// and character emission times from push times and the fixed character spacing.
module tb_uart_mmio;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;
    logic        uart_in_valid;
    logic [7:0]  uart_in_ch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_idle_ch = 0;
    int bad_idle_rdata = 0;

    int         obs_t[$];
    logic [7:0] obs_c[$];
    int         m_push_t[$];
    int         m_emit_t[$];
    logic [7:0] m_ch[$];
    int         m_last_emit = -1000;

    uart_mmio #(.FIFO_DEPTH(DEPTH), .TX_GAP(GAP)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_wen_i        (req_wen),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_wmask_i      (req_wmask),
        .resp_valid_o     (resp_valid),
        .resp_rdata_o     (resp_rdata),
        .uart_out_valid_o (uart_out_valid),
        .uart_out_ch_o    (uart_out_ch),
        .uart_in_valid_o  (uart_in_valid),
        .uart_in_ch_i     (uart_in_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_out_valid === 1'b1) begin
            obs_t.push_back(cyc);
            obs_c.push_back(uart_out_ch);
        end else if (uart_out_ch !== 8'd0) begin
            bad_idle_ch++;
        end
        if (resp_valid !== 1'b1 && resp_rdata !== 64'd0) bad_idle_rdata++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: a character pushed in cycle p appears two cycles later, but never
    // sooner than GAP+2 cycles after the previous character.
    function automatic void model_reset();
        m_push_t.delete();
        m_emit_t.delete();
        m_ch.delete();
        m_last_emit = -1000;
    endfunction

    function automatic void model_push(int p, logic [7:0] c);
        int e = p + 2;
        if (m_last_emit + GAP + 2 > e) e = m_last_emit + GAP + 2;
        m_last_emit = e;
        m_push_t.push_back(p);
        m_emit_t.push_back(e);
        m_ch.push_back(c);
    endfunction

    function automatic int model_count(int c);
        int n = 0;
        foreach (m_push_t[i]) if (m_push_t[i] < c) n++;
        foreach (m_emit_t[i]) if (m_emit_t[i] < c) n--;
        return n;
    endfunction

    function automatic logic [63:0] model_status(int n);
        logic [63:0] s = 64'd0;
        s[0]   = (n == DEPTH);
        s[1]   = (n == 0);
        s[7:4] = (n > 15) ? 4'hF : 4'(n);
        return s;
    endfunction

    // Called on a falling edge; returns on the next falling edge, where the response is visible.
    task automatic drive_req(input bit wen, input bit a3, input logic [7:0] d, input bit m0,
                             output bit acc, output bit inv, output bit exp_acc);
        exp_acc   = !(wen && !a3 && model_count(cyc) == DEPTH);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = {$urandom, $urandom};
        req_addr[3] = a3;
        req_wdata = {$urandom, $urandom};
        req_wdata[7:0] = d;
        req_wmask = 8'($urandom);
        req_wmask[0] = m0;
        #1;
        acc = req_ready;
        inv = uart_in_valid;
        if (exp_acc && wen && !a3 && m0) model_push(cyc, d);
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    task automatic wait_drain();
        while (cyc <= m_last_emit + 2) @(negedge clk);
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic fresh();
        obs_t.delete();
        obs_c.delete();
        m_push_t.delete();
        m_emit_t.delete();
        m_ch.delete();
    endtask

    task automatic test_reset();
        bit acc, inv, ea;
        rst_n = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'd0;
        req_wdata = 64'd0; req_wmask = 8'd0; uart_in_ch = 8'h55;
        repeat (2) @(negedge clk);
        checks++;
        if (uart_in_valid !== 1'b0) begin
            errors++; $display("FAIL reset_in_valid: got %0b expected 0", uart_in_valid);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || uart_out_valid !== 1'b0 || uart_out_ch !== 8'd0) begin
            errors++; $display("FAIL reset_outputs: got rv=%0b rd=%0h ov=%0b ch=%0h expected all 0",
                               resp_valid, resp_rdata, uart_out_valid, uart_out_ch);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        fresh();
        @(negedge clk);
        drive_req(1'b0, 1'b1, 8'd0, 1'b0, acc, inv, ea);
        checks++;
        if (acc !== 1'b1) begin
            errors++; $display("FAIL reset_status_ready: got %0b expected 1", acc);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h2) begin
            errors++; $display("FAIL reset_status: got rv=%0b rd=%0h expected rv=1 rd=2", resp_valid, resp_rdata);
        end
        checks++;
        if (uart_out_valid !== 1'b0 || uart_out_ch !== 8'd0 || uart_in_valid !== 1'b0) begin
            errors++; $display("FAIL reset_uart_idle: got ov=%0b ch=%0h iv=%0b expected 0",
                               uart_out_valid, uart_out_ch, uart_in_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL resp_pulse_width: got %0b expected 0", resp_valid);
        end
    endtask

    task automatic test_single_store();
        bit acc, inv, ea;
        int t0;
        fresh();
        t0 = cyc;
        drive_req(1'b1, 1'b0, 8'h41, 1'b1, acc, inv, ea);
        checks++;
        if (acc !== 1'b1 || resp_valid !== 1'b1 || resp_rdata !== 64'd0) begin
            errors++; $display("FAIL single_store_resp: got acc=%0b rv=%0b rd=%0h expected 1 1 0",
                               acc, resp_valid, resp_rdata);
        end
        wait_drain();
        checks++;
        if (obs_t.size() != 1) begin
            errors++; $display("FAIL single_store_count: got %0d chars expected 1", obs_t.size());
        end else begin
            checks++;
            if (obs_t[0] != t0 + 2 || obs_c[0] !== 8'h41) begin
                errors++; $display("FAIL single_store_char: got cycle %0d ch %0h expected cycle %0d ch 41",
                                   obs_t[0] - t0, obs_c[0], 2);
            end
        end
    endtask

    task automatic test_load_data();
        bit acc, inv, ea;
        logic [7:0] ch;
        for (int i = 0; i < 4; i++) begin
            ch = (i == 0) ? 8'h7A : 8'($urandom);
            uart_in_ch = ch;
            drive_req(1'b0, 1'b0, 8'd0, 1'b0, acc, inv, ea);
            checks++;
            if (acc !== 1'b1 || inv !== 1'b1) begin
                errors++; $display("FAIL load_data_strobe: got acc=%0b iv=%0b expected 1 1", acc, inv);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== {56'd0, ch}) begin
                errors++; $display("FAIL load_data_value: got rv=%0b rd=%0h expected rv=1 rd=%0h",
                                   resp_valid, resp_rdata, ch);
            end
        end
        drive_req(1'b0, 1'b1, 8'd0, 1'b0, acc, inv, ea);
        checks++;
        if (inv !== 1'b0) begin
            errors++; $display("FAIL status_no_strobe: got iv=%0b expected 0", inv);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, inv, ea;
        int n = 0;
        int stalls = 0;
        int guard = 0;
        fresh();
        while (n < 12 && guard < 200) begin
            drive_req(1'b1, 1'b0, 8'(8'h30 + n), 1'b1, acc, inv, ea);
            checks++;
            if (acc !== ea) begin
                errors++; $display("FAIL stream_ready: char %0d got %0b expected %0b", n, acc, ea);
            end
            checks++;
            if (resp_valid !== ea) begin
                errors++; $display("FAIL stream_resp: char %0d got %0b expected %0b", n, resp_valid, ea);
            end
            if (ea) n++; else stalls++;
            guard++;
        end
        checks++;
        if (stalls == 0 || n != 12) begin
            errors++; $display("FAIL stream_stall: got stalls=%0d sent=%0d expected stalls>0 sent=12", stalls, n);
        end
        wait_drain();
        checks++;
        if (obs_t.size() != 12) begin
            errors++; $display("FAIL stream_count: got %0d chars expected 12", obs_t.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (obs_c[i] !== 8'(8'h30 + i) || obs_t[i] != m_emit_t[i]) begin
                    errors++; $display("FAIL stream_char %0d: got ch %0h at %0d expected ch %0h at %0d",
                                       i, obs_c[i], obs_t[i], 8'(8'h30 + i), m_emit_t[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_t[i] - obs_t[i-1] != GAP + 2) begin
                        errors++; $display("FAIL stream_spacing %0d: got %0d expected %0d",
                                           i, obs_t[i] - obs_t[i-1], GAP + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_wmask0();
        bit acc, inv, ea;
        fresh();
        drive_req(1'b1, 1'b0, 8'h5A, 1'b0, acc, inv, ea);
        checks++;
        if (acc !== 1'b1 || resp_valid !== 1'b1 || resp_rdata !== 64'd0) begin
            errors++; $display("FAIL wmask0_resp: got acc=%0b rv=%0b rd=%0h expected 1 1 0", acc, resp_valid, resp_rdata);
        end
        drive_req(1'b1, 1'b1, 8'h66, 1'b1, acc, inv, ea);
        checks++;
        if (acc !== 1'b1 || resp_valid !== 1'b1 || resp_rdata !== 64'd0) begin
            errors++; $display("FAIL status_store_resp: got acc=%0b rv=%0b rd=%0h expected 1 1 0", acc, resp_valid, resp_rdata);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (obs_t.size() != 0) begin
            errors++; $display("FAIL wmask0_chars: got %0d chars expected 0", obs_t.size());
        end
        drive_req(1'b0, 1'b1, 8'd0, 1'b0, acc, inv, ea);
        checks++;
        if (resp_rdata !== 64'h2) begin
            errors++; $display("FAIL wmask0_status: got %0h expected 2", resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, inv, ea;
        bit found = 1'b0;
        fresh();
        for (int i = 0; i < 5; i++) drive_req(1'b1, 1'b0, 8'(8'h61 + i), 1'b1, acc, inv, ea);
        for (int i = 0; i < 20 && !found; i++) begin
            if (uart_out_valid === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_mid_send: got no character within 20 cycles expected one");
        end
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uart_out_valid !== 1'b0 || uart_out_ch !== 8'd0 || resp_valid !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++; $display("FAIL reset_mid_async: got ov=%0b ch=%0h rv=%0b rd=%0h expected all 0",
                               uart_out_valid, uart_out_ch, resp_valid, resp_rdata);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fresh();
        repeat (60) @(negedge clk);
        checks++;
        if (obs_t.size() != 0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flush: got %0d chars rv=%0b expected 0 chars rv=0",
                               obs_t.size(), resp_valid);
        end
        drive_req(1'b0, 1'b1, 8'd0, 1'b0, acc, inv, ea);
        checks++;
        if (resp_rdata !== 64'h2) begin
            errors++; $display("FAIL reset_mid_status: got %0h expected 2", resp_rdata);
        end
    endtask

    task automatic test_random();
        bit acc, inv, ea;
        bit wen, a3, m0;
        logic [7:0] d, ch;
        logic [63:0] st, exp_rd;
        int op;
        fresh();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
            op  = $urandom_range(0, 9);
            wen = (op < 6);
            a3  = (op == 5) || (op >= 8);
            m0  = ($urandom_range(0, 3) != 0);
            d   = 8'($urandom);
            ch  = 8'($urandom);
            uart_in_ch = ch;
            st = model_status(model_count(cyc));
            drive_req(wen, a3, d, m0, acc, inv, ea);
            exp_rd = wen ? 64'd0 : (a3 ? st : {56'd0, ch});
            checks++;
            if (acc !== ea || inv !== (ea && !wen && !a3)) begin
                errors++; $display("FAIL rand_handshake %0d: got acc=%0b iv=%0b expected %0b %0b",
                                   i, acc, inv, ea, ea && !wen && !a3);
            end
            checks++;
            if (resp_valid !== ea || (ea && resp_rdata !== exp_rd)) begin
                errors++; $display("FAIL rand_resp %0d: got rv=%0b rd=%0h expected rv=%0b rd=%0h",
                                   i, resp_valid, resp_rdata, ea, exp_rd);
            end
        end
        wait_drain();
        checks++;
        if (obs_t.size() != m_ch.size()) begin
            errors++; $display("FAIL rand_count: got %0d chars expected %0d", obs_t.size(), m_ch.size());
        end else begin
            foreach (m_ch[i]) begin
                checks++;
                if (obs_c[i] !== m_ch[i] || obs_t[i] != m_emit_t[i]) begin
                    errors++; $display("FAIL rand_char %0d: got ch %0h at %0d expected ch %0h at %0d",
                                       i, obs_c[i], obs_t[i], m_ch[i], m_emit_t[i]);
                end
            end
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (bad_idle_ch != 0 || bad_idle_rdata != 0) begin
            errors++; $display("FAIL idle_outputs: got %0d nonzero ch and %0d nonzero rdata cycles expected 0",
                               bad_idle_ch, bad_idle_rdata);
        end
    endtask

    initial begin
        uart_in_ch = 8'd0;
        test_reset();
        test_single_store();
        test_load_data();
        test_back_to_back();
        test_wmask0();
        test_reset_mid();
        test_random();
        test_idle_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
